// File: rtl/cdcm8_tx_link_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cdcm8_tx_link_sequencer
// Brief    : CDCM-8 TX lane bring-up sequencer (reset hold, scan wait, training,
//            link-up) with timeout/retry and a valid/ready user word path.
// Revision : 1.0 - initial release
// ============================================================================
module cdcm8_tx_link_sequencer #(
  parameter int         kRstCycles    = 16,
  parameter int         kScanTimeout  = 1024,
  parameter int         kStableCycles = 8,
  parameter int         kTrainFrames  = 64,
  parameter logic [7:0] kTrainPattern = 8'hF0,
  parameter logic [7:0] kIdlePattern  = 8'h00,
  parameter int         kCntW         = 16
) (
  input  logic       clkDivIn,
  input  logic       rstIn,
  input  logic       initReq,
  input  logic       scanFinished,
  input  logic [7:0] dataIn,
  input  logic       dataValid,
  output logic       dataReady,
  output logic [7:0] txData,
  output logic       txIoReset,
  output logic       txReady,
  output logic [3:0] retryCount,
  output logic       timeoutErr
);

  typedef enum logic [1:0] {
    RESET_HOLD = 2'd0,
    WAIT_SCAN  = 2'd1,
    TRAIN      = 2'd2,
    LINKUP     = 2'd3
  } stateT;

  localparam longint           cCntLimit     = longint'(1) << kCntW;
  localparam logic [kCntW-1:0] cRstLast      = kCntW'(kRstCycles - 1);
  localparam logic [kCntW-1:0] cScanLast     = kCntW'(kScanTimeout - 1);
  localparam logic [kCntW-1:0] cStableTarget = kCntW'(kStableCycles);
  localparam logic [kCntW-1:0] cTrainLast    = kCntW'(kTrainFrames - 1);

  if (kRstCycles < 2 || longint'(kRstCycles) >= cCntLimit ||
      kStableCycles < 1 || longint'(kStableCycles) >= cCntLimit ||
      kScanTimeout <= kStableCycles || longint'(kScanTimeout) >= cCntLimit ||
      kTrainFrames < 1 || longint'(kTrainFrames) >= cCntLimit) begin : g_paramCheck
    $error("cdcm8_tx_link_sequencer: parameter out of range for kCntW");
  end

  stateT            r_state;
  logic [kCntW-1:0] r_cnt;
  logic [kCntW-1:0] r_stable;
  logic [7:0]       r_txData;
  logic             r_txIoReset;
  logic             r_txReady;
  logic [3:0]       r_retryCount;
  logic             r_timeoutErr;

  logic [kCntW-1:0] w_stableNext;
  logic [3:0]       w_retryInc;
  logic             w_handshake;

  // Combinational so a word is never accepted on a teardown cycle.
  assign dataReady    = (r_state == LINKUP) & scanFinished & ~initReq & ~rstIn;
  assign w_handshake  = dataValid & dataReady;
  assign w_stableNext = scanFinished ? r_stable + 1'b1 : '0;
  assign w_retryInc   = (r_retryCount == 4'hF) ? 4'hF : r_retryCount + 4'd1;

  always_ff @(posedge clkDivIn) begin
    if (rstIn) begin
      r_state      <= RESET_HOLD;
      r_cnt        <= '0;
      r_stable     <= '0;
      r_txData     <= kTrainPattern;
      r_txIoReset  <= 1'b1;
      r_txReady    <= 1'b0;
      r_retryCount <= 4'd0;
      r_timeoutErr <= 1'b0;
    end else if (initReq) begin
      r_state      <= RESET_HOLD;
      r_cnt        <= '0;
      r_stable     <= '0;
      r_txData     <= kTrainPattern;
      r_txIoReset  <= 1'b1;
      r_txReady    <= 1'b0;
      r_retryCount <= 4'd0;
      r_timeoutErr <= 1'b0;
    end else begin
      case (r_state)
        RESET_HOLD: begin
          r_txData  <= kTrainPattern;
          r_txReady <= 1'b0;
          if (r_cnt == cRstLast) begin
            r_state     <= WAIT_SCAN;
            r_cnt       <= '0;
            r_stable    <= '0;
            r_txIoReset <= 1'b0;
          end else begin
            r_cnt       <= r_cnt + 1'b1;
            r_txIoReset <= 1'b1;
          end
        end
        WAIT_SCAN: begin
          r_txData <= kTrainPattern;
          r_stable <= w_stableNext;
          if (w_stableNext == cStableTarget) begin
            r_state <= TRAIN;
            r_cnt   <= '0;
          end else if (r_cnt == cScanLast) begin
            r_state      <= RESET_HOLD;
            r_cnt        <= '0;
            r_txIoReset  <= 1'b1;
            r_retryCount <= w_retryInc;
            r_timeoutErr <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        TRAIN: begin
          r_txData <= kTrainPattern;
          if (!scanFinished) begin
            r_state      <= RESET_HOLD;
            r_cnt        <= '0;
            r_txIoReset  <= 1'b1;
            r_retryCount <= w_retryInc;
          end else if (r_cnt == cTrainLast) begin
            r_state   <= LINKUP;
            r_cnt     <= '0;
            r_txData  <= kIdlePattern;
            r_txReady <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LINKUP: begin
          if (!scanFinished) begin
            r_state      <= RESET_HOLD;
            r_cnt        <= '0;
            r_txData     <= kTrainPattern;
            r_txIoReset  <= 1'b1;
            r_txReady    <= 1'b0;
            r_retryCount <= w_retryInc;
          end else begin
            r_txData <= w_handshake ? dataIn : kIdlePattern;
          end
        end
        default: begin
          r_state <= RESET_HOLD;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign txData     = r_txData;
  assign txIoReset  = r_txIoReset;
  assign txReady    = r_txReady;
  assign retryCount = r_retryCount;
  assign timeoutErr = r_timeoutErr;

endmodule
`default_nettype wire

// File: doc/cdcm8_tx_link_sequencer.md
Name: cdcm8_tx_link_sequencer

Overview:
Sequences bring-up of one CDCM-8 serializer TX lane, running in the clkDivIn (word) domain. It drives the lane's ioReset and 8-bit parallel word (dInFromDevice) and watches the lane's scanFinished. It walks the lane through reset hold, scan wait, training and link-up, with timeout/retry. Once the link is up it passes user words onto the lane with a valid/ready handshake and fills idle slots with an idle word.

Parameters:
kRstCycles, 16, clkDivIn cycles txIoReset is held high per RESET_HOLD visit (2..2^kCntW-1)
kScanTimeout, 1024, max WAIT_SCAN cycles before retry (> kStableCycles)
kStableCycles, 8, consecutive scanFinished=1 cycles required to leave WAIT_SCAN (>=1)
kTrainFrames, 64, words of training pattern sent in TRAIN (>=1)
kTrainPattern, 8'hF0, training word
kIdlePattern, 8'h00, idle word in LINKUP
kCntW, 16, width of the shared state counter

Ports:
clkDivIn  in  1  word clock, shared with the serializer CLKDIV
rstIn  in  1  synchronous, active-high reset
initReq  in  1  single-cycle request to restart bring-up
scanFinished  in  1  from the TX lane
dataIn  in  8  user word
dataValid  in  1  dataIn valid
dataReady  out  1  word accepted when dataValid & dataReady
txData  out  8  to the lane dInFromDevice
txIoReset  out  1  to the lane ioReset
txReady  out  1  link up (state LINKUP)
retryCount  out  4  failed-bring-up count, saturates at 15
timeoutErr  out  1  sticky: a scan timeout occurred

Behaviour:
- One clock (clkDivIn). Reset is synchronous, active-high, on rstIn. All outputs are registered except dataReady.
- Reset values: state=RESET_HOLD, counter=0, txIoReset=1, txData=kTrainPattern, txReady=0, retryCount=0, timeoutErr=0. dataReady=0 while rstIn=1.
- Priority per cycle: rstIn > initReq > loss/timeout > normal progress.
- RESET_HOLD:
  - txIoReset=1 and txData=kTrainPattern.
  - txIoReset is 1 on exactly kRstCycles consecutive cycles per visit, counted from the first cycle after rstIn falls or after entry.
  - Then go to WAIT_SCAN with counter cleared.
- WAIT_SCAN:
  - txIoReset=0, txData=kTrainPattern.
  - A stable counter increments while scanFinished=1 and clears to 0 on any scanFinished=0.
  - When the stable count reaches kStableCycles, go to TRAIN.
  - Otherwise, after kScanTimeout cycles in the state: go to RESET_HOLD, retryCount+1 (saturating), timeoutErr<=1.
- TRAIN:
  - txData=kTrainPattern for exactly kTrainFrames cycles, then go to LINKUP.
  - scanFinished=0 in any TRAIN cycle: go to RESET_HOLD, retryCount+1.
- LINKUP:
  - txReady=1.
  - dataReady = (state==LINKUP) & scanFinished & ~initReq & ~rstIn (combinational, so no word is accepted during a teardown cycle).
  - On a handshake, txData<=dataIn (1-cycle latency to txData); otherwise txData<=kIdlePattern.
  - Back-to-back handshakes give one word per cycle with no bubbles.
  - scanFinished=0: go to RESET_HOLD, txReady<=0, retryCount+1.
- initReq in any state: next state is RESET_HOLD with a fresh kRstCycles hold. initReq clears timeoutErr and retryCount, and does not count as a retry.
- Counter width: the counter is kCntW bits and never wraps. Every parameter must be < 2^kCntW; this is checked at elaboration.
- Transitions into RESET_HOLD take effect on the next edge: txIoReset=1 and txReady=0 from that edge.

Test Plan:
- Power-up: rstIn 1→0, scanFinished tied 1. txIoReset=1 for 16 cycles, WAIT_SCAN 8 cycles, txData=8'hF0 for 64 cycles, then txReady=1 and txData=8'h00. retryCount=0.
- Timeout: scanFinished=0 for 3000 cycles. Two full retries occur (each 16 hold + 1024 wait cycles); retryCount=2, timeoutErr=1. Raising scanFinished afterwards reaches LINKUP with timeoutErr still 1.
- Debounce: in WAIT_SCAN, scanFinished high 7 cycles, low 1, high 8. TRAIN is entered only after the second run (stable count restarts).
- Data path: in LINKUP, stream 0x11,0x22,0x33 with dataValid held high, then drop dataValid. txData shows 0x11,0x22,0x33 on consecutive cycles one cycle after acceptance, then 0x00.
- Loss: scanFinished→0 in LINKUP with dataValid=1. dataReady=0 in that same cycle, the word is not consumed, txReady=0 and txIoReset=1 next cycle, retryCount+1.
- initReq mid-TRAIN after a prior timeout: RESET_HOLD next cycle, retryCount=0, timeoutErr=0, full 16-cycle hold.
